rf_sb: RTL and testbench

Parametrised register file with hazard scoreboard; the next-generation replacement for the fixed 32×32 datapath register file. Two combinational read ports and one clocked write port, with optional write-to-read bypass. Register 0 is hardwired to zero, and all storage clears on reset. A per-register busy bit, set when an instruction issues and cleared at writeback, produces a stall request for the pipeline control unit.

---
 rtl/rf_sb.sv | 88 ++++++++
 tb/tb_rf_sb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_sb.sv
// Register file (2^AW x WIDTH, R0 hardwired to zero) with per-register busy scoreboard.
// Latency: reads, Busy and Stall are combinational; writes and busy updates land at the clock edge.
// Backpressure: none inside the block; Stall is a request to pipeline control, which holds IssEn low.
module rf_sb #(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             WrEn,
    input  logic [AW-1:0]    Rw,
    input  logic [WIDTH-1:0] busW,
    input  logic [AW-1:0]    Ra,
    input  logic [AW-1:0]    Rb,
    output logic [WIDTH-1:0] busA,
    output logic [WIDTH-1:0] busB,
    input  logic             UseA,
    input  logic             UseB,
    input  logic             IssEn,
    input  logic [AW-1:0]    IssRd,
    output logic             BusyA,
    output logic             BusyB,
    output logic             Stall
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic w_wr;
    logic w_iss;
    logic w_byp_a;
    logic w_byp_b;

    // A write or issue aimed at R0 has no effect on either storage or scoreboard.
    assign w_wr  = WrEn && (Rw != '0);
    assign w_iss = IssEn && (IssRd != '0);

    // Same-cycle forwarding only exists when the bypass is built in.
    assign w_byp_a = (BYPASS != 0) && WrEn && (Rw == Ra);
    assign w_byp_b = (BYPASS != 0) && WrEn && (Rw == Rb);

    // Register storage: clear everything on reset, otherwise take the writeback.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[Rw] <= busW;
        end
    end

    // Scoreboard: writeback clears, issue sets; the set is applied last so a new producer wins.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_wr) begin
                r_busy[Rw] <= 1'b0;
            end
            if (w_iss) begin
                r_busy[IssRd] <= 1'b1;
            end
        end
    end

    // Read ports: R0 reads zero, a matching writeback is forwarded, else the stored value.
    always_comb begin
        busA = '0;
        busB = '0;
        if (Ra != '0) begin
            busA = w_byp_a ? busW : r_mem[Ra];
        end
        if (Rb != '0) begin
            busB = w_byp_b ? busW : r_mem[Rb];
        end
    end

    // Hazard detect: a pending write being resolved by a forwarded writeback is not a hazard.
    always_comb begin
        BusyA = (Ra != '0) && r_busy[Ra] && !w_byp_a;
        BusyB = (Rb != '0) && r_busy[Rb] && !w_byp_b;
        Stall = (UseA && BusyA) || (UseB && BusyB);
    end

endmodule

// File: tb/tb_rf_sb.sv
// Bench for rf_sb: three instances (32x5 bypass, 32x5 no bypass, 16x3 bypass) share stimulus.
// The driver pushes per-instance expectations into a queue; a negedge monitor pops and compares.
// Expectations come from an array-based model of the registers and busy bits.
module tb_rf_sb;
    logic        Clk = 1'b0;
    logic        Rst_n, WrEn, UseA, UseB, IssEn;
    logic [4:0]  Rw, Ra, Rb, IssRd;
    logic [31:0] busW;

    logic [31:0] busA0, busB0, busA1, busB1;
    logic [15:0] busA2, busB2;
    logic        BusyA0, BusyB0, Stall0;
    logic        BusyA1, BusyB1, Stall1;
    logic        BusyA2, BusyB2, Stall2;

    always #5 Clk = ~Clk;

    rf_sb #(.WIDTH(32), .AW(5), .BYPASS(1)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .WrEn(WrEn), .Rw(Rw), .busW(busW),
        .Ra(Ra), .Rb(Rb), .busA(busA0), .busB(busB0), .UseA(UseA), .UseB(UseB),
        .IssEn(IssEn), .IssRd(IssRd), .BusyA(BusyA0), .BusyB(BusyB0), .Stall(Stall0));

    rf_sb #(.WIDTH(32), .AW(5), .BYPASS(0)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .WrEn(WrEn), .Rw(Rw), .busW(busW),
        .Ra(Ra), .Rb(Rb), .busA(busA1), .busB(busB1), .UseA(UseA), .UseB(UseB),
        .IssEn(IssEn), .IssRd(IssRd), .BusyA(BusyA1), .BusyB(BusyB1), .Stall(Stall1));

    rf_sb #(.WIDTH(16), .AW(3), .BYPASS(1)) u2 (
        .Clk(Clk), .Rst_n(Rst_n), .WrEn(WrEn), .Rw(Rw[2:0]), .busW(busW[15:0]),
        .Ra(Ra[2:0]), .Rb(Rb[2:0]), .busA(busA2), .busB(busB2), .UseA(UseA), .UseB(UseB),
        .IssEn(IssEn), .IssRd(IssRd[2:0]), .BusyA(BusyA2), .BusyB(BusyB2), .Stall(Stall2));

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
        logic        st;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_mem  [3][32];
    logic        m_busy [3][32];
    bit          model_valid = 0;

    function automatic logic [4:0] amask(int c);
        return (c == 2) ? 5'd7 : 5'd31;
    endfunction

    function automatic logic [31:0] wmask(int c);
        return (c == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic bit has_bypass(int c);
        return c != 1;
    endfunction

    // Reference behaviour of a read port seen by configuration c.
    function automatic logic [31:0] exp_data(int c, logic [4:0] addr);
        logic [4:0] a  = addr & amask(c);
        logic [4:0] w  = Rw & amask(c);
        if (a == 0) return 32'h0;
        if (has_bypass(c) && WrEn && w == a) return busW & wmask(c);
        return m_mem[c][a];
    endfunction

    function automatic logic exp_busy(int c, logic [4:0] addr);
        logic [4:0] a  = addr & amask(c);
        logic [4:0] w  = Rw & amask(c);
        if (a == 0) return 1'b0;
        if (has_bypass(c) && WrEn && w == a) return 1'b0;
        return m_busy[c][a];
    endfunction

    task automatic push_expected();
        for (int c = 0; c < 3; c++) begin
            exp_t e;
            e.c  = c;
            e.a  = exp_data(c, Ra);
            e.b  = exp_data(c, Rb);
            e.ba = exp_busy(c, Ra);
            e.bb = exp_busy(c, Rb);
            e.st = (UseA & e.ba) | (UseB & e.bb);
            q.push_back(e);
        end
    endtask

    // Model state change at the clock edge, using the inputs that were held across it.
    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            logic [4:0] w = Rw & amask(c);
            logic [4:0] d = IssRd & amask(c);
            if (!Rst_n) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[c][i]  = 32'h0;
                    m_busy[c][i] = 1'b0;
                end
            end else begin
                if (WrEn && w != 0) begin
                    m_mem[c][w]  = busW & wmask(c);
                    m_busy[c][w] = 1'b0;
                end
                if (IssEn && d != 0) m_busy[c][d] = 1'b1;
            end
        end
        if (!Rst_n) model_valid = 1;
    endtask

    task automatic cycle(input logic rst_n, input logic wr, input logic [4:0] rw,
                         input logic [31:0] bw, input logic [4:0] ra, input logic [4:0] rb,
                         input logic ua, input logic ub, input logic iss, input logic [4:0] ird);
        Rst_n = rst_n; WrEn = wr; Rw = rw; busW = bw; Ra = ra; Rb = rb;
        UseA = ua; UseB = ub; IssEn = iss; IssRd = ird;
        if (model_valid) push_expected();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[inst%0d] t=%0t: got %h expected %h", name, c, $time, act, exp);
    endtask

    // Monitor: the outputs are combinational, so every pending expectation is compared mid-cycle.
    always @(negedge Clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] aa, ab;
            logic        xa, xb, xs;
            e = q.pop_front();
            case (e.c)
                0: begin aa = busA0; ab = busB0; xa = BusyA0; xb = BusyB0; xs = Stall0; end
                1: begin aa = busA1; ab = busB1; xa = BusyA1; xb = BusyB1; xs = Stall1; end
                default: begin
                    aa = {16'h0, busA2}; ab = {16'h0, busB2};
                    xa = BusyA2; xb = BusyB2; xs = Stall2;
                end
            endcase
            chk("busA",  e.c, aa, e.a);
            chk("busB",  e.c, ab, e.b);
            chk("BusyA", e.c, {31'h0, xa}, {31'h0, e.ba});
            chk("BusyB", e.c, {31'h0, xb}, {31'h0, e.bb});
            chk("Stall", e.c, {31'h0, xs}, {31'h0, e.st});
        end
    end

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        Rst_n = 1'b0; WrEn = 0; Rw = 0; busW = 0; Ra = 0; Rb = 0;
        UseA = 0; UseB = 0; IssEn = 0; IssRd = 0;
        @(posedge Clk); #1;

        // Initial reset, then reset values at a few addresses.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 11, 5, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 31, 7, 1, 1, 0, 0);

        // Reset clears a stored value and an in-flight busy bit; the reset-cycle write is lost.
        cycle(1, 1, 11, 32'h1111_1111, 0, 0, 0, 0, 1, 11);
        cycle(1, 0, 0, 0, 11, 11, 1, 1, 0, 0);
        cycle(0, 1, 12, 32'h2222_2222, 11, 12, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 11, 12, 1, 1, 0, 0);

        // R0 ignores writes and issues.
        cycle(1, 1, 0, 32'hDEAD_BEEF, 0, 0, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);

        // Bypass vs. no-bypass visibility of a writeback.
        cycle(1, 1, 8, 32'h0000_0001, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 8, 32'h0000_000A, 8, 8, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 8, 8, 0, 0, 0, 0);

        // Hazard on R18 raised by issue and resolved by writeback.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 18);
        cycle(1, 0, 0, 0, 18, 0, 1, 0, 0, 0);
        cycle(1, 1, 18, 32'h0000_1818, 18, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 18, 0, 1, 0, 0, 0);

        // Set/clear collision on R19: the new issue keeps it busy.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 19);
        cycle(1, 1, 19, 32'h0000_1919, 0, 19, 0, 1, 1, 19);
        cycle(1, 0, 0, 0, 0, 19, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 19, 0, 0, 0, 0);

        // R7 round trip and independent busy bits over addresses 1..7.
        cycle(1, 1, 7, 32'h1234_A5A5, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 7, 7, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) cycle(1, 0, 0, 0, 5'(i), 5'(i - 1), 1, 1, 1, 5'(i));
        for (int i = 1; i < 8; i++) cycle(1, 1, 5'(i), 32'(i * 3), 5'(i), 5'((i % 7) + 1), 1, 1, 0, 0);
        for (int i = 1; i < 8; i++) cycle(1, 0, 0, 0, 5'(i), 5'(8 - i), 1, 1, 0, 0);

        // Randomized traffic biased towards a small register set to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                  rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rnd_addr());
        end

        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
